// File: rtl/ahb_uart_tx_streamer.sv
// AHB-Lite master that drains a byte FIFO into a memory-mapped UART:
// it programs the divider, polls CTRL until not busy, then writes DATA.
module ahb_uart_tx_streamer #(
  parameter logic [31:0] BASE_ADDR  = 32'hbf40_0000,
  parameter logic [31:0] DIV_RESET  = 32'h0000_0002,
  parameter int          FIFO_DEPTH = 8,
  parameter int          POLL_GAP   = 4,
  parameter int          BUSY_BIT   = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        cfg_load,
  input  logic [31:0] cfg_div,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [15:0] sent_count,
  output logic        idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);
  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;
  localparam logic [31:0] ADDR_DATA = BASE_ADDR;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_DVDR = BASE_ADDR + 32'd8;

  typedef enum logic [2:0] {
    S_CFG_A, S_CFG_D, S_WAIT, S_POLL_A, S_POLL_D, S_GAP, S_WR_A, S_WR_D
  } state_t;

  state_t          state;
  logic [1:0]      rst_sync;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, empty, push, pop;
  logic [31:0]     pending_div;
  logic            cfg_pending;
  logic [7:0]      wr_byte, head_byte;
  logic            have_byte;
  logic [GW-1:0]   gap_cnt;
  logic            addr_accept, data_done, cfg_accept;
  logic            unused_rdata;

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign HSIZE     = 3'b010;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign in_ready = rst_sync[1] && !full;
  assign push  = in_valid && in_ready;

  assign addr_accept = (HTRANS == TR_NONSEQ) && HREADY;
  assign data_done   = HREADY && ((state == S_CFG_D) || (state == S_POLL_D) || (state == S_WR_D));
  assign cfg_accept  = (state == S_CFG_A) && addr_accept;
  // A byte is popped only once; an error retry reuses the latched copy.
  assign pop       = (state == S_WR_A) && addr_accept && !have_byte;
  assign head_byte = have_byte ? wr_byte : mem[rd_ptr[AW-1:0]];
  assign idle      = (state == S_WAIT) && empty && !cfg_pending;
  assign unused_rdata = ^HRDATA;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // A new cfg_load always wins over clearing the request it replaces.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pending_div <= DIV_RESET;
      cfg_pending <= 1'b1;
    end else if (cfg_load) begin
      pending_div <= cfg_div;
      cfg_pending <= 1'b1;
    end else if (cfg_accept) begin
      cfg_pending <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                err_flag <= 1'b0;
    else if (data_done && HRESP) err_flag <= 1'b1;
    else if (err_clr)            err_flag <= 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_CFG_A;
      HTRANS     <= TR_IDLE;
      HADDR      <= 32'h0;
      HWRITE     <= 1'b0;
      HWDATA     <= 32'h0;
      wr_byte    <= 8'h0;
      have_byte  <= 1'b0;
      gap_cnt    <= '0;
      sent_count <= 16'h0;
    end else begin
      case (state)
        S_CFG_A: begin
          if (HTRANS == TR_IDLE) begin
            HTRANS <= TR_NONSEQ;
            HADDR  <= ADDR_DVDR;
            HWRITE <= 1'b1;
          end else if (HREADY) begin
            HTRANS <= TR_IDLE;
            HWDATA <= pending_div;
            state  <= S_CFG_D;
          end
        end
        S_CFG_D: begin
          if (HREADY) state <= HRESP ? S_CFG_A : S_WAIT;
        end
        S_WAIT: begin
          if (cfg_pending) begin
            state  <= S_CFG_A;
            HTRANS <= TR_NONSEQ;
            HADDR  <= ADDR_DVDR;
            HWRITE <= 1'b1;
          end else if (!empty) begin
            state  <= S_POLL_A;
            HTRANS <= TR_NONSEQ;
            HADDR  <= ADDR_CTRL;
            HWRITE <= 1'b0;
          end
        end
        S_POLL_A: begin
          if (HTRANS == TR_IDLE) begin
            HTRANS <= TR_NONSEQ;
            HADDR  <= ADDR_CTRL;
            HWRITE <= 1'b0;
          end else if (HREADY) begin
            HTRANS <= TR_IDLE;
            HWDATA <= 32'h0;
            state  <= S_POLL_D;
          end
        end
        S_POLL_D: begin
          if (HREADY) begin
            if (HRESP) begin
              state <= S_POLL_A;
            end else if (HRDATA[BUSY_BIT]) begin
              if (POLL_GAP == 0) begin
                state  <= S_POLL_A;
                HTRANS <= TR_NONSEQ;
                HADDR  <= ADDR_CTRL;
                HWRITE <= 1'b0;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else begin
              state  <= S_WR_A;
              HTRANS <= TR_NONSEQ;
              HADDR  <= ADDR_DATA;
              HWRITE <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state  <= S_POLL_A;
            HTRANS <= TR_NONSEQ;
            HADDR  <= ADDR_CTRL;
            HWRITE <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_WR_A: begin
          if (HTRANS == TR_IDLE) begin
            HTRANS <= TR_NONSEQ;
            HADDR  <= ADDR_DATA;
            HWRITE <= 1'b1;
          end else if (HREADY) begin
            HTRANS    <= TR_IDLE;
            HWDATA    <= {24'h0, head_byte};
            wr_byte   <= head_byte;
            have_byte <= 1'b1;
            state     <= S_WR_D;
          end
        end
        S_WR_D: begin
          if (HREADY) begin
            if (HRESP) begin
              state <= S_WR_A;
            end else begin
              have_byte  <= 1'b0;
              sent_count <= sent_count + 16'd1;
              state      <= S_WAIT;
            end
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
